// File: rtl/uart_rx.sv
// UART receiver: 1 start, NB_DATA data bits (LSB first), 1 stop, no parity, 16x oversampled.
// Good frames update o_rx_data with an o_rx_done pulse; a low stop bit pulses o_frame_err.
module uart_rx #(
    parameter int NB_DATA = 8,
    parameter int NB_TICK = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_rx_data,
    output logic               o_rx_done,
    output logic               o_frame_err
);
    localparam int TW = $clog2(NB_TICK);
    localparam int BW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
    localparam logic [TW-1:0] TICK_MID  = TW'(NB_TICK / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(NB_TICK - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(NB_DATA - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               rx_meta_q, rx_meta_d;
    logic               rx_s_q, rx_s_d;
    logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [NB_DATA-1:0] shift_q, shift_d;
    logic [NB_DATA-1:0] rx_data_q, rx_data_d;
    logic               rx_done_q, rx_done_d;
    logic               frame_err_q, frame_err_d;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= IDLE;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Start detection in IDLE runs every clock; all other timing advances on i_tick only.
    always_comb begin
        rx_meta_d   = i_rx;
        rx_s_d      = rx_meta_q;
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d    = START;
                    tick_cnt_d = '0;
                end
            end
            START: begin
                if (i_tick) begin
                    if (tick_cnt_q == TICK_MID) begin
                        if (!rx_s_q) begin
                            state_d    = DATA;
                            tick_cnt_d = '0;
                            bit_cnt_d  = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end
            DATA: begin
                if (i_tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        shift_d    = {rx_s_q, shift_q[NB_DATA-1:1]};
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BW'(1);
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end
            STOP: begin
                if (i_tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        if (rx_s_q) begin
                            rx_data_d = shift_q;
                            rx_done_d = 1'b1;
                            state_d   = IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = BREAK;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end
            // A held-low line must return high before a new start can be recognised.
            BREAK: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
            end
        endcase
    end

    assign o_rx_data   = rx_data_q;
    assign o_rx_done   = rx_done_q;
    assign o_frame_err = frame_err_q;

endmodule
